// File: rtl/sign_mag_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sign_mag_alu_pipe
//  Purpose  : Two-stage sign-magnitude add/subtract/accumulate unit with
//             valid/ready handshake, overflow saturate/wrap, -0 removal and
//             an internal accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module sign_mag_alu_pipe #(
    parameter int N   = 4,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N:0]   in_a,
    input  logic [N:0]   in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_sum,
    output logic         out_ovf,
    output logic [N:0]   acc_val
);

    localparam logic [1:0] c_op_add  = 2'b00;
    localparam logic [1:0] c_op_sub  = 2'b01;
    localparam logic [1:0] c_op_load = 2'b11;

    // Stage 1 registers
    logic         s1_valid_q, s1_valid_d;
    logic [1:0]   s1_op_q,    s1_op_d;
    logic [N:0]   s1_a_q,     s1_a_d;
    logic [N:0]   s1_b_q,     s1_b_d;
    // Stage 2 registers and accumulator
    logic         out_valid_q, out_valid_d;
    logic [N:0]   out_sum_q,   out_sum_d;
    logic         out_ovf_q,   out_ovf_d;
    logic [N:0]   acc_q,       acc_d;

    logic         w_adv;
    logic         w_in_ready;
    logic         w_accept;
    logic [N:0]   w_res;
    logic         w_res_ovf;

    // Handshake: S2 may advance when empty or drained; an ACC/LOAD in S1
    // blocks input until it has written the accumulator.
    always_comb begin
        w_adv      = !out_valid_q || out_ready;
        w_in_ready = rst_n && (!s1_valid_q || w_adv) && !(s1_valid_q && s1_op_q[1]);
        w_accept   = in_valid && w_in_ready;
    end

    // Stage 1 next state: capture op, a and the effective second operand
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            if (in_op == c_op_add) begin
                s1_b_d = in_b;
            end else if (in_op == c_op_sub) begin
                s1_b_d = {~in_b[N], in_b[N-1:0]};
            end else begin
                s1_b_d = acc_q;
            end
        end else if (w_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Sign-magnitude arithmetic on the S1 contents
    always_comb begin
        logic         a_sign, b_sign, a_ge, res_sign;
        logic [N-1:0] a_mag, b_mag, max_mag, min_mag, res_mag;
        logic [N:0]   sum_full;
        a_sign   = s1_a_q[N];
        b_sign   = s1_b_q[N];
        a_mag    = s1_a_q[N-1:0];
        b_mag    = s1_b_q[N-1:0];
        a_ge     = (a_mag >= b_mag);
        max_mag  = a_ge ? a_mag : b_mag;
        min_mag  = a_ge ? b_mag : a_mag;
        sum_full = {1'b0, a_mag} + {1'b0, b_mag};
        res_sign = a_sign;
        res_mag  = a_mag;
        w_res_ovf = 1'b0;
        if (s1_op_q == c_op_load) begin
            res_sign = a_sign;
            res_mag  = a_mag;
        end else if (a_sign == b_sign) begin
            res_sign  = a_sign;
            w_res_ovf = sum_full[N];
            if (sum_full[N] && (SAT != 0)) begin
                res_mag = {N{1'b1}};
            end else begin
                res_mag = sum_full[N-1:0];
            end
        end else begin
            // Ties fall to the a-operand side, and then the magnitude is 0
            res_sign = a_ge ? a_sign : b_sign;
            res_mag  = max_mag - min_mag;
        end
        // Never emit negative zero
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        w_res = {res_sign, res_mag};
    end

    // Stage 2 and accumulator next state: load on advance, hold while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_q;
        if (w_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sum_d = w_res;
                out_ovf_d = w_res_ovf;
                if (s1_op_q[1]) begin
                    acc_d = w_res;
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign acc_val   = acc_q;

endmodule
`default_nettype wire
